imem_arbiter: RTL

//  Arbitrates the single-port instruction memory between fetch (read-only, every

---
 rtl/imem_arbiter_pkg.sv | 21 ++
 rtl/imem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// imem_arbiter_pkg
//   Shared definitions for the instruction-memory arbiter:
//     - default address / data widths of the instruction memory
//     - arbiter FSM state encoding
//     - the NOP instruction word returned when no fetch data is valid
// ----------------------------------------------------------------------------
package imem_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
//   Shares one single-port instruction memory between the fetch stage and
//   the program loader. Normally every fetch request goes straight to the
//   memory. A load burst stalls fetch, writes ld_len words starting at
//   ld_base (wrapping at the top of memory), then spends one FLUSH cycle
//   telling fetch to restart from ld_base.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   f_req / f_addr      fetch read request and word address
//   f_gnt               fetch request sent to memory this cycle
//   f_valid / f_rdata   fetched word, one cycle after f_gnt
//   fetch_hold          fetch must freeze its PC and issue NOPs
//   fetch_redirect      one-cycle pulse, PC <= redirect_addr
//   redirect_addr       restart address, valid with fetch_redirect
//   ld_start            start a burst; ld_base / ld_len sampled with it
//   ld_wvalid/ld_wdata  loader write data
//   ld_wready           arbiter accepts ld_wdata this cycle
//   ld_done             one-cycle pulse when the burst has finished
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata
//                       single-port memory interface, 1-cycle read latency
// ----------------------------------------------------------------------------
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              fetch_hold,
    output logic              fetch_redirect,
    output logic [ADDR_W-1:0] redirect_addr,

    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_wvalid,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_wready,
    output logic              ld_done,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // A burst can never usefully cover more than the whole memory.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
        if (len > DEPTH) begin
            return DEPTH;
        end
        return len;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [ADDR_W:0]   len_q,   len_d;
    logic [ADDR_W:0]   cnt_q,   cnt_d;
    logic              f_valid_q;

    logic [ADDR_W-1:0] wr_addr;
    logic              burst_end;

    // Natural ADDR_W-bit overflow gives the wrap from the top word to 0.
    assign wr_addr   = base_q + cnt_q[ADDR_W-1:0];
    assign burst_end = (cnt_q == len_q);

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        len_d          = len_q;
        cnt_d          = cnt_q;

        f_gnt          = 1'b0;
        fetch_hold     = 1'b0;
        fetch_redirect = 1'b0;
        redirect_addr  = '0;
        ld_wready      = 1'b0;
        ld_done        = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        unique case (state_q)
            ST_FETCH: begin
                f_gnt    = f_req;
                mem_en   = f_req;
                mem_addr = f_addr;
                // The fetch granted alongside ld_start is still returned.
                if (ld_start) begin
                    base_d  = ld_base;
                    len_d   = clamp_len(ld_len);
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                fetch_hold = 1'b1;
                mem_addr   = wr_addr;
                mem_wdata  = ld_wdata;
                // Only a zero-length burst reaches here with count == len;
                // it moves on without accepting any loader data.
                ld_wready  = !burst_end;
                if (burst_end) begin
                    state_d = ST_FLUSH;
                end else if (ld_wvalid) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == len_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                fetch_hold     = 1'b1;
                fetch_redirect = 1'b1;
                redirect_addr  = base_q;
                ld_done        = 1'b1;
                state_d        = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Keep every output quiet while reset is held.
        if (rst) begin
            f_gnt          = 1'b0;
            fetch_hold     = 1'b0;
            fetch_redirect = 1'b0;
            redirect_addr  = '0;
            ld_wready      = 1'b0;
            ld_done        = 1'b0;
            mem_en         = 1'b0;
            mem_we         = 1'b0;
            mem_addr       = '0;
            mem_wdata      = '0;
        end
    end

    // ------------------------------------------------------------------------
    // State, burst registers and fetch return tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            f_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            f_valid_q <= f_gnt;
        end
    end

    // The memory already registers its read data; returning it in the cycle
    // after the grant avoids a second cycle of fetch latency. Non-valid
    // cycles present a NOP.
    assign f_valid = f_valid_q;
    assign f_rdata = f_valid_q ? mem_rdata : DATA_W'(NOP_WORD);

endmodule
